// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared widths, FSM states and round/saturate helper for the band mixer
package eq_pkg;
    localparam int IN_W      = 48;
    localparam int GAIN_W    = 16;
    localparam int OUT_W     = 24;
    localparam int SHIFT     = 29;
    localparam int PROD_W    = IN_W + GAIN_W;
    localparam int MAX_BANDS = 16;
    // Sized for the largest band count so any NUM_BANDS sum fits without overflow
    localparam int ACC_W     = PROD_W + $clog2(MAX_BANDS);

    localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h4000;

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, ROUND} mix_state_t;

    typedef struct packed {
        logic                    clip;
        logic signed [OUT_W-1:0] y;
    } sat_t;

    function automatic sat_t sat_round(input logic signed [ACC_W-1:0] acc);
        localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (SHIFT - 1);
        localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
        localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
        logic signed [ACC_W-1:0] sum;
        sat_t r;
        sum = acc + HALF;
        sum = sum >>> SHIFT;
        r.clip = (sum > SAT_MAX) || (sum < SAT_MIN);
        if (sum > SAT_MAX)
            r.y = SAT_MAX[OUT_W-1:0];
        else if (sum < SAT_MIN)
            r.y = SAT_MIN[OUT_W-1:0];
        else
            r.y = sum[OUT_W-1:0];
        return r;
    endfunction
endpackage

// File: rtl/eq_band_mixer_if.sv
// rtl/eq_band_mixer_if.sv - band-mixer control, band input and stereo output bundle
interface eq_band_mixer_if import eq_pkg::*; #(
    parameter int NUM_BANDS = 4
) ();
    logic                       audio_en;
    logic                       gain_wr_en;
    logic [3:0]                 gain_select;
    logic [7:0]                 gain_wr_lsb_data;
    logic [7:0]                 gain_wr_msb_data;
    logic                       status_clr;
    logic                       l_data_valid;
    logic                       r_data_valid;
    logic [NUM_BANDS*IN_W-1:0]  l_band_in;
    logic [NUM_BANDS*IN_W-1:0]  r_band_in;
    logic [OUT_W-1:0]           l_data_out;
    logic [OUT_W-1:0]           r_data_out;
    logic                       out_valid;
    logic                       busy;
    logic                       clip_l;
    logic                       clip_r;
    logic                       overrun;
    logic                       sync_err;

    modport master (
        output audio_en, gain_wr_en, gain_select, gain_wr_lsb_data, gain_wr_msb_data,
               status_clr, l_data_valid, r_data_valid, l_band_in, r_band_in,
        input  l_data_out, r_data_out, out_valid, busy, clip_l, clip_r, overrun, sync_err
    );

    modport slave (
        input  audio_en, gain_wr_en, gain_select, gain_wr_lsb_data, gain_wr_msb_data,
               status_clr, l_data_valid, r_data_valid, l_band_in, r_band_in,
        output l_data_out, r_data_out, out_valid, busy, clip_l, clip_r, overrun, sync_err
    );
endinterface

// File: rtl/eq_mac_lane.sv
// rtl/eq_mac_lane.sv - one channel: band capture, serial MAC, round/saturate and clip flag
module eq_mac_lane import eq_pkg::*; #(
    parameter int NUM_BANDS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      capture,
    input  logic                      mac_en,
    input  logic                      acc_en,
    input  logic                      round_en,
    input  logic                      clip_clr,
    input  logic [IDX_W-1:0]          idx,
    input  logic signed [GAIN_W-1:0]  gain,
    input  logic [NUM_BANDS*IN_W-1:0] band_in,
    output logic signed [OUT_W-1:0]   data_out,
    output logic                      clip
);
    logic signed [IN_W-1:0]   band_q [NUM_BANDS];
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    sat_t                     rnd;

    always_comb rnd = sat_round(acc);

    // Datapath registers are always loaded before use, so they carry no reset
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int b = 0; b < NUM_BANDS; b++)
                band_q[b] <= band_in[b*IN_W +: IN_W];
        end
        if (mac_en)
            prod <= PROD_W'(band_q[idx]) * PROD_W'(gain);
        if (capture)
            acc <= '0;
        else if (acc_en)
            acc <= acc + ACC_W'(prod);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out <= '0;
            clip     <= 1'b0;
        end else begin
            if (round_en)
                data_out <= rnd.y;
            if (round_en && rnd.clip)
                clip <= 1'b1;
            else if (clip_clr)
                clip <= 1'b0;
        end
    end
endmodule

// File: rtl/eq_band_mixer.sv
// rtl/eq_band_mixer.sv - per-band gain and stereo band sum with one shared MAC pass per sample
module eq_band_mixer import eq_pkg::*; #(
    parameter int                NUM_BANDS = 4,
    parameter logic [GAIN_W-1:0] GAIN_RST  = GAIN_UNITY
) (
    input  logic           clk,
    input  logic           reset_n,
    eq_band_mixer_if.slave bus
);
    localparam int IDX_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

    mix_state_t        state, state_nx;
    logic [IDX_W-1:0]  idx;
    logic [GAIN_W-1:0] gain_reg [NUM_BANDS];
    logic [GAIN_W-1:0] gain_act [NUM_BANDS];
    logic              start, start_ok, ovr_set, sync_set, gain_wr_ok;
    logic              capture, mac_en, acc_en, round_en, last_band;
    logic              out_valid, overrun, sync_err, clip_l, clip_r;
    logic [OUT_W-1:0]  l_out, r_out;

    always_comb begin
        start      = bus.l_data_valid | bus.r_data_valid;
        start_ok   = bus.audio_en && start && (state == IDLE);
        ovr_set    = bus.audio_en && start && (state != IDLE);
        sync_set   = bus.audio_en && (bus.l_data_valid != bus.r_data_valid);
        gain_wr_ok = bus.gain_wr_en && (32'(bus.gain_select) < NUM_BANDS);
        last_band  = (idx == IDX_W'(NUM_BANDS - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        mac_en   = 1'b0;
        acc_en   = 1'b0;
        round_en = 1'b0;
        case (state)
            IDLE: begin
                capture = start_ok;
                if (start_ok)
                    state_nx = MAC;
            end
            MAC: begin
                mac_en = 1'b1;
                acc_en = (idx != '0);
                if (last_band)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                acc_en   = 1'b1;
                state_nx = ROUND;
            end
            ROUND: begin
                round_en = bus.audio_en;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (!bus.audio_en)
            state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (capture)
            idx <= '0;
        else if (mac_en)
            idx <= idx + IDX_W'(1);
    end

    // Writes land in gain_reg at any time; a pass only ever sees the set latched at its start
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                gain_reg[b] <= GAIN_RST;
                gain_act[b] <= GAIN_RST;
            end
        end else begin
            if (capture)
                gain_act <= gain_reg;
            if (gain_wr_ok)
                gain_reg[bus.gain_select[IDX_W-1:0]] <= {bus.gain_wr_msb_data, bus.gain_wr_lsb_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            out_valid <= round_en;
            if (ovr_set)
                overrun <= 1'b1;
            else if (bus.status_clr)
                overrun <= 1'b0;
            if (sync_set)
                sync_err <= 1'b1;
            else if (bus.status_clr)
                sync_err <= 1'b0;
        end
    end

    eq_mac_lane #(.NUM_BANDS(NUM_BANDS), .IDX_W(IDX_W)) u_lane_l (
        .clk      (clk),
        .reset_n  (reset_n),
        .capture  (capture),
        .mac_en   (mac_en),
        .acc_en   (acc_en),
        .round_en (round_en),
        .clip_clr (bus.status_clr),
        .idx      (idx),
        .gain     (gain_act[idx]),
        .band_in  (bus.l_band_in),
        .data_out (l_out),
        .clip     (clip_l)
    );

    eq_mac_lane #(.NUM_BANDS(NUM_BANDS), .IDX_W(IDX_W)) u_lane_r (
        .clk      (clk),
        .reset_n  (reset_n),
        .capture  (capture),
        .mac_en   (mac_en),
        .acc_en   (acc_en),
        .round_en (round_en),
        .clip_clr (bus.status_clr),
        .idx      (idx),
        .gain     (gain_act[idx]),
        .band_in  (bus.r_band_in),
        .data_out (r_out),
        .clip     (clip_r)
    );

    assign bus.l_data_out = l_out;
    assign bus.r_data_out = r_out;
    assign bus.out_valid  = out_valid;
    assign bus.busy       = (state != IDLE);
    assign bus.clip_l     = clip_l;
    assign bus.clip_r     = clip_r;
    assign bus.overrun    = overrun;
    assign bus.sync_err   = sync_err;
endmodule

// File: tb/tb_eq_band_mixer.sv
// tb/tb_eq_band_mixer.sv - directed bench with a sample-level reference model for eq_band_mixer
module tb_eq_band_mixer;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    eq_band_mixer_if #(.NUM_BANDS(N)) bus ();

    eq_band_mixer #(.NUM_BANDS(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: exact sum of band*gain, then round-half-up by 2^29 and clamp to 24 bits
    function automatic logic [24:0] mix(input logic [N*48-1:0] flat, input logic [15:0] g [N]);
        logic signed [127:0] sum, y;
        sum = '0;
        for (int i = 0; i < N; i++)
            sum = sum + 128'($signed(flat[i*48 +: 48])) * 128'($signed(g[i]));
        y = (sum + 128'sd268435456) >>> 29;
        if (y > 128'sd8388607)  return {1'b1, 24'h7FFFFF};
        if (y < -128'sd8388608) return {1'b1, 24'h800000};
        return {1'b0, y[23:0]};
    endfunction

    logic [15:0] m_gain [N];
    int          m_rem = 0;
    logic        m_live = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_clip_l = 1'b0, m_clip_r = 1'b0, m_ovr = 1'b0, m_sync = 1'b0;
    logic [23:0] m_l = '0, m_r = '0;
    logic [24:0] pend_l = '0, pend_r = '0;

    always @(posedge clk) begin : model
        logic s_cl, s_cr, s_ov, s_sy, st;
        m_live  = 1'b1;
        m_valid = 1'b0;
        s_cl = 0; s_cr = 0; s_ov = 0; s_sy = 0;
        st = bus.l_data_valid | bus.r_data_valid;
        if (!reset_n) begin
            for (int i = 0; i < N; i++) m_gain[i] = 16'h4000;
            m_rem = 0; m_l = '0; m_r = '0;
            m_clip_l = 0; m_clip_r = 0; m_ovr = 0; m_sync = 0;
        end else begin
            if (bus.audio_en) begin
                if (m_rem > 0) begin
                    if (st) s_ov = 1;
                    m_rem--;
                    if (m_rem == 0) begin
                        m_valid = 1'b1;
                        m_l = pend_l[23:0]; m_r = pend_r[23:0];
                        s_cl = pend_l[24];  s_cr = pend_r[24];
                    end
                end else if (st) begin
                    pend_l = mix(bus.l_band_in, m_gain);
                    pend_r = mix(bus.r_band_in, m_gain);
                    m_rem  = N + 2;
                end
                s_sy = (bus.l_data_valid != bus.r_data_valid);
            end else begin
                m_rem = 0;
            end
            m_clip_l = s_cl | (m_clip_l & ~bus.status_clr);
            m_clip_r = s_cr | (m_clip_r & ~bus.status_clr);
            m_ovr    = s_ov | (m_ovr & ~bus.status_clr);
            m_sync   = s_sy | (m_sync & ~bus.status_clr);
            if (bus.gain_wr_en && bus.gain_select < N)
                m_gain[bus.gain_select] = {bus.gain_wr_msb_data, bus.gain_wr_lsb_data};
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("out_valid", bus.out_valid, m_valid);
            check("busy", bus.busy, m_rem > 0);
            check("l_data_out", bus.l_data_out, m_l);
            check("r_data_out", bus.r_data_out, m_r);
            check("clip_l", bus.clip_l, m_clip_l);
            check("clip_r", bus.clip_r, m_clip_r);
            check("overrun", bus.overrun, m_ovr);
            check("sync_err", bus.sync_err, m_sync);
        end
    end

    task automatic set_bands(input logic signed [47:0] l0, l1, l2, l3, r0, r1, r2, r3);
        bus.l_band_in = {l3, l2, l1, l0};
        bus.r_band_in = {r3, r2, r1, r0};
    endtask

    task automatic pulse_start(input logic lv, input logic rv);
        bus.l_data_valid = lv;
        bus.r_data_valid = rv;
        @(negedge clk);
        bus.l_data_valid = 1'b0;
        bus.r_data_valid = 1'b0;
    endtask

    task automatic gain_write(input logic [3:0] sel, input logic [15:0] val);
        bus.gain_wr_en       = 1'b1;
        bus.gain_select      = sel;
        bus.gain_wr_msb_data = val[15:8];
        bus.gain_wr_lsb_data = val[7:0];
        @(negedge clk);
        bus.gain_wr_en = 1'b0;
    endtask

    task automatic clear_status();
        bus.status_clr = 1'b1;
        @(negedge clk);
        bus.status_clr = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) check("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic count_valid(input int n, output int c);
        c = 0;
        repeat (n) begin
            if (bus.out_valid) c++;
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int lat, cnt;
        bus.audio_en = 1'b0; bus.gain_wr_en = 1'b0; bus.gain_select = '0;
        bus.gain_wr_lsb_data = '0; bus.gain_wr_msb_data = '0; bus.status_clr = 1'b0;
        bus.l_data_valid = 1'b0; bus.r_data_valid = 1'b0;
        set_bands(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_l_data", bus.l_data_out, 0);
        reset_n = 1'b1;
        bus.audio_en = 1'b1;
        @(negedge clk);

        // unity gain, band0 only; latency of 7 clocks from the start clock
        set_bands(48'sd32768000, 0, 0, 0, -48'sd229376, 0, 0, 0);
        pulse_start(1, 1);
        wait_valid(lat);
        check("t1_latency", lat, 7);
        check("t1_l", bus.l_data_out, 24'd1000);
        check("t1_r", bus.r_data_out, 24'hFFFFF9);

        // back-to-back start on the out_valid clock, saturating sum on L only
        set_bands(48'sd68719476736, 48'sd68719476736, 48'sd68719476736, 48'sd68719476736, 0, 0, 0, 0);
        pulse_start(1, 1);
        wait_valid(lat);
        check("t2_latency", lat, 7);
        check("t2_l_sat", bus.l_data_out, 24'h7FFFFF);
        check("t2_clip_l", bus.clip_l, 1);
        check("t2_clip_r", bus.clip_r, 0);
        clear_status();

        // negative unity gain on band2
        gain_write(4'd2, 16'hC000);
        set_bands(0, 0, 0, 0, 0, 0, -48'sd163840, 0);
        pulse_start(1, 1);
        wait_valid(lat);
        check("t3_r_neg_gain", bus.r_data_out, 24'd5);

        // rounding boundary: acc = 2^28 rounds up, 2^28-1 rounds down
        gain_write(4'd0, 16'h0001);
        set_bands(48'sd268435456, 0, 0, 0, 48'sd268435455, 0, 0, 0);
        pulse_start(1, 1);
        wait_valid(lat);
        check("t4_round_up", bus.l_data_out, 24'd1);
        check("t4_round_down", bus.r_data_out, 24'd0);
        gain_write(4'd0, 16'h4000);
        gain_write(4'd2, 16'h4000);

        // overrun: second start three clocks into a pass
        set_bands(0, 48'sd3276800, 0, 0, 0, 0, 0, 0);
        pulse_start(1, 1);
        repeat (2) @(negedge clk);
        pulse_start(1, 1);
        check("t5_overrun_set", bus.overrun, 1);
        count_valid(14, cnt);
        check("t5_single_valid", cnt, 1);
        clear_status();
        check("t5_overrun_clr", bus.overrun, 0);

        // gain change mid-pass only affects the next sample; out-of-range select ignored
        pulse_start(1, 1);
        gain_write(4'd1, 16'h2000);
        wait_valid(lat);
        check("t6_old_gain", bus.l_data_out, 24'd100);
        pulse_start(1, 1);
        wait_valid(lat);
        check("t6_new_gain", bus.l_data_out, 24'd50);
        gain_write(4'd9, 16'h0000);
        pulse_start(1, 1);
        wait_valid(lat);
        check("t6_sel9_ignored", bus.l_data_out, 24'd50);

        // mismatched strobes still start a pass
        pulse_start(1, 0);
        check("t7_sync_err", bus.sync_err, 1);
        wait_valid(lat);
        check("t7_latency", lat, 7);
        clear_status();

        // abort in the middle of MAC
        set_bands(48'sd32768000, 0, 0, 0, 0, 0, 0, 0);
        pulse_start(1, 1);
        repeat (2) @(negedge clk);
        bus.audio_en = 1'b0;
        @(negedge clk);
        check("t8_busy_abort", bus.busy, 0);
        bus.audio_en = 1'b1;
        count_valid(12, cnt);
        check("t8_no_valid", cnt, 0);
        check("t8_l_hold", bus.l_data_out, 24'd50);

        // reset restores unity gains and clears outputs
        gain_write(4'd0, 16'h1000);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("t9_rst_l", bus.l_data_out, 0);
        check("t9_rst_busy", bus.busy, 0);
        check("t9_rst_clip", bus.clip_l, 0);
        reset_n = 1'b1;
        set_bands(48'sd98304, 0, 0, 0, 0, 0, 0, 0);
        pulse_start(1, 1);
        wait_valid(lat);
        check("t9_unity_after_rst", bus.l_data_out, 24'd3);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
